text_line_renderer: RTL
=======================

# text_line_renderer

Sequential rasterizer that turns a line of ASCII characters into a stream of RGB565 pixels for the LCD pixel writer. It owns a small character buffer and walks it row by row, querying the external combinational 4x7 font ROM (char, x, y → bit) once per pixel. It emits one pixel per cycle over a valid/ready handshake, with a one-column background gap between glyphs.

## Interface
- N_CHARS, 16, characters per line (1..64); text box is N_CHARS*5 × 7 pixels
- FG_COLOR, 16'hFFFF, RGB565 colour for font bit = 1
- BG_COLOR, 16'h0000, RGB565 colour for font bit = 0 and for gap columns
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- char_we  in  1  character buffer write strobe
- char_addr  in  6  buffer slot; writes with addr ≥ N_CHARS are ignored
- char_data  in  8  ASCII code
- start  in  1  begin rendering; sampled only in IDLE
- x0  in  9  box origin column, latched at start
- y0  in  9  box origin row, latched at start
- font_char  out  8  to font ROM: current character
- font_x  out  3  to font ROM: glyph column 0..4
- font_y  out  3  to font ROM: glyph row 0..6
- font_bit  in  1  from font ROM, combinational same cycle
- px_valid  out  1  pixel output valid
- px_ready  in  1  downstream accepts pixel
- px_x  out  9  pixel column
- px_y  out  9  pixel row
- px_color  out  16  pixel colour
- busy  out  1  high from the cycle after start through the done pulse
- done  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- Buffer: N_CHARS × 8 bits, all slots reset to 8'h20 (space). Writes are allowed at any time. A write during render affects only pixels not yet loaded into the output register.
- Counters: row (0..6), cidx (0..N_CHARS-1), gx (0..4). Order is gx fastest, then cidx, then row.
- font_char = buf[cidx], font_x = gx, font_y = row. These are driven combinationally from the counters in every state.
- Colour rule: BG_COLOR if gx == 4, else FG_COLOR if font_bit, else BG_COLOR.
- px_x = x0 + cidx*5 + gx and px_y = y0 + row, both mod 512. Wrap-around is silent and produces no error.
- FSM states:
  - IDLE: busy = 0. start → latch x0/y0, clear counters, go to RENDER. start is ignored in all other states.
  - RENDER: when !px_valid || px_ready, load {px_x, px_y, px_color} from the counters, set px_valid, and advance the counters. If the loaded pixel is the last (row 6, cidx N_CHARS-1, gx 4), go to DRAIN.
  - DRAIN: when px_ready && px_valid, clear px_valid and go to DONE.
  - DONE: done = 1 for one cycle, then go to IDLE.
- Output register is stable while px_valid && !px_ready; px_x, px_y and px_color must not change.
- Total pixels per render = 35*N_CHARS (560 for the default).

## Timing
- Reset values: px_valid 0, px_x 0, px_y 0, px_color BG_COLOR, busy 0, done 0, counters 0, state IDLE. font_char = 8'h20, font_x = 0, font_y = 0.
- start high in cycle 0 → RENDER in cycle 1 → first px_valid in cycle 2.
- With px_ready held high, throughput is 1 pixel/cycle with no bubbles. The last pixel is valid in cycle 35*N_CHARS+1 and done pulses in the following cycle.
- Backpressure: a pixel is accepted on a cycle with px_valid && px_ready. A load may occur in the same cycle as an accept, so full throughput is kept.
- start held high continuously restarts only after returning to IDLE; there is one IDLE cycle minimum between renders.
- rst asserted mid-render: all outputs return to reset values immediately, and the buffer returns to spaces.

## Test plan
- Reset, then start with default buffer, x0 = 0, y0 = 0, px_ready = 1 → 560 pixels, all BG_COLOR, first pixel (0,0), last pixel (79,6); done in cycle 562; busy high cycles 1..562.
- Write "10" to slots 0..1, render at x0 = 10, y0 = 20 → row 0 FG exactly at x = 12, 15..18; gap columns x = 14 and 19 are BG; all pixels match the font model.
- Random px_ready (50%) with the "10" text → identical pixel sequence to the ready = 1 run; outputs held stable whenever a pixel is valid and not accepted; exactly 560 accepts.
- x0 = 500, y0 = 510 → px_x wraps after 511 to 0, px_y wraps to 0..4 on rows 2..6; no hang; done asserts.
- Pulse start while busy and write char_addr = 20 → start ignored; pixel count stays 560; addr-20 write has no effect.
- Assert rst at pixel 100 → px_valid, busy and done drop asynchronously; the next start renders spaces from pixel 0.

Source files
------------

// File: rtl/text_line_renderer.sv
`default_nettype none
// ============================================================================
// Module   : text_line_renderer
// Purpose  : Rasterises a buffered line of ASCII text into RGB565 pixels,
//            one per cycle over valid/ready, querying an external 4x7 font ROM.
// Revision : 1.0 - initial release
// ============================================================================
module text_line_renderer #(
  parameter int          N_CHARS  = 16,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_we,
  input  logic [5:0]  char_addr,
  input  logic [7:0]  char_data,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [8:0]  y0,
  output logic [7:0]  font_char,
  output logic [2:0]  font_x,
  output logic [2:0]  font_y,
  input  logic        font_bit,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [8:0]  px_x,
  output logic [8:0]  px_y,
  output logic [15:0] px_color,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] c_last_cidx = 6'(N_CHARS - 1);
  localparam logic [6:0] c_n_chars   = 7'(N_CHARS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RENDER = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  x0_q, x0_d, y0_q, y0_d;
  logic [2:0]  row_q, row_d, gx_q, gx_d;
  logic [5:0]  cidx_q, cidx_d;
  logic        px_valid_q, px_valid_d;
  logic [8:0]  px_x_q, px_x_d, px_y_q, px_y_d;
  logic [15:0] px_color_q, px_color_d;
  // Sized to the full address space so any 6-bit index is legal; slots at or
  // beyond N_CHARS are never written and stay constant.
  logic [7:0]  buf_q [64];
  logic [7:0]  buf_d [64];

  logic [8:0]  w_pix_x, w_pix_y;
  logic [15:0] w_pix_color;
  logic        w_last_gx, w_last_cidx, w_last_row, w_last_pixel;

  assign font_char = buf_q[cidx_q];
  assign font_x    = gx_q;
  assign font_y    = row_q;

  assign px_valid  = px_valid_q;
  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign px_color  = px_color_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  assign w_last_gx    = (gx_q == 3'd4);
  assign w_last_cidx  = (cidx_q == c_last_cidx);
  assign w_last_row   = (row_q == 3'd6);
  assign w_last_pixel = w_last_gx && w_last_cidx && w_last_row;

  // Coordinates wrap modulo 512 by plain 9-bit truncation.
  assign w_pix_x     = x0_q + ({3'b000, cidx_q} * 9'd5) + {6'b000000, gx_q};
  assign w_pix_y     = y0_q + {6'b000000, row_q};
  assign w_pix_color = w_last_gx ? BG_COLOR : (font_bit ? FG_COLOR : BG_COLOR);

  always_comb begin
    buf_d = buf_q;
    if (char_we && ({1'b0, char_addr} < c_n_chars)) begin
      buf_d[char_addr] = char_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    row_d      = row_q;
    cidx_d     = cidx_q;
    gx_d       = gx_q;
    px_valid_d = px_valid_q;
    px_x_d     = px_x_q;
    px_y_d     = px_y_q;
    px_color_d = px_color_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          row_d   = 3'd0;
          cidx_d  = 6'd0;
          gx_d    = 3'd0;
          state_d = ST_RENDER;
        end
      end
      ST_RENDER: begin
        // Load whenever the output slot is empty or being drained this cycle.
        if (!px_valid_q || px_ready) begin
          px_valid_d = 1'b1;
          px_x_d     = w_pix_x;
          px_y_d     = w_pix_y;
          px_color_d = w_pix_color;
          if (w_last_gx) begin
            gx_d = 3'd0;
            if (w_last_cidx) begin
              cidx_d = 6'd0;
              row_d  = w_last_row ? 3'd0 : row_q + 3'd1;
            end else begin
              cidx_d = cidx_q + 6'd1;
            end
          end else begin
            gx_d = gx_q + 3'd1;
          end
          if (w_last_pixel) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (px_valid_q && px_ready) begin
          px_valid_d = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x0_q       <= 9'd0;
      y0_q       <= 9'd0;
      row_q      <= 3'd0;
      cidx_q     <= 6'd0;
      gx_q       <= 3'd0;
      px_valid_q <= 1'b0;
      px_x_q     <= 9'd0;
      px_y_q     <= 9'd0;
      px_color_q <= BG_COLOR;
      for (int i = 0; i < 64; i++) begin
        buf_q[i] <= 8'h20;
      end
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      row_q      <= row_d;
      cidx_q     <= cidx_d;
      gx_q       <= gx_d;
      px_valid_q <= px_valid_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      px_color_q <= px_color_d;
      buf_q      <= buf_d;
    end
  end

endmodule
`default_nettype wire
